// File: rtl/fp_mem_sequencer_if.sv
// fp_mem_sequencer_if
//   Bundles the decode-side FP memory request fields, the data-RAM port and
//   the load-return/stall signals of fp_mem_sequencer.
//   master : decode stage + data RAM side (drives requests and dMemOut)
//   slave  : the sequencer (drives RAM address/data/write, Freeze, Busy, RData)
//   Signals:
//     Start, CHn_Req, CHn_Wr, CHn_Addr, CHn_WData : request fields per channel
//     dMemOut                                     : RAM read data
//     dAddr, dWr, dMemIn                          : RAM address/write port
//     Freeze, Busy                                : stall and activity flags
//     CHn_RData, CHn_RValid                       : assembled load data + pulse
interface fp_mem_sequencer_if #(
  parameter int FPRegWidth = 64,
  parameter int AddrWidth  = 20,
  parameter int DataWidth  = 32
);
  logic                  Start;
  logic                  CH1_Req;
  logic                  CH1_Wr;
  logic [AddrWidth-1:0]  CH1_Addr;
  logic [FPRegWidth-1:0] CH1_WData;
  logic                  CH2_Req;
  logic                  CH2_Wr;
  logic [AddrWidth-1:0]  CH2_Addr;
  logic [FPRegWidth-1:0] CH2_WData;
  logic [DataWidth-1:0]  dMemOut;
  logic [AddrWidth-1:0]  dAddr;
  logic                  dWr;
  logic [DataWidth-1:0]  dMemIn;
  logic                  Freeze;
  logic                  Busy;
  logic [FPRegWidth-1:0] CH1_RData;
  logic [FPRegWidth-1:0] CH2_RData;
  logic                  CH1_RValid;
  logic                  CH2_RValid;

  modport master (
    output Start, CH1_Req, CH1_Wr, CH1_Addr, CH1_WData,
           CH2_Req, CH2_Wr, CH2_Addr, CH2_WData, dMemOut,
    input  dAddr, dWr, dMemIn, Freeze, Busy,
           CH1_RData, CH2_RData, CH1_RValid, CH2_RValid
  );

  modport slave (
    input  Start, CH1_Req, CH1_Wr, CH1_Addr, CH1_WData,
           CH2_Req, CH2_Wr, CH2_Addr, CH2_WData, dMemOut,
    output dAddr, dWr, dMemIn, Freeze, Busy,
           CH1_RData, CH2_RData, CH1_RValid, CH2_RValid
  );
endinterface

// File: rtl/fp_mem_sequencer.sv
// fp_mem_sequencer
//   Serialises the 64-bit FP loads/stores of both VLIW FP channels onto the
//   single 32-bit data-RAM port. Each channel takes a low-word beat then a
//   high-word beat; CH1 is always serviced before CH2. Fetch/decode is frozen
//   from the accepting Start cycle until the transfer sequence finishes.
//   Ports:
//     clock : system clock, rising edge
//     Reset : synchronous active-high reset
//     bus   : fp_mem_sequencer_if.slave (requests, RAM port, Freeze/Busy,
//             assembled load data and one-cycle RValid pulses)
//   FPRegWidth must equal 2*DataWidth.
module fp_mem_sequencer #(
  parameter int FPRegWidth = 64,
  parameter int AddrWidth  = 20,
  parameter int DataWidth  = 32
) (
  input  logic              clock,
  input  logic              Reset,
  fp_mem_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    C1_LO = 3'd1,
    C1_HI = 3'd2,
    C2_LO = 3'd3,
    C2_HI = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Request fields captured on accept; stable until the next accept, which
  // can only happen after the sequence has returned to IDLE.
  logic                  req1, wr1, req2, wr2;
  logic [AddrWidth-1:0]  addr1, addr2;
  logic [FPRegWidth-1:0] wdata1, wdata2;

  logic accept;
  logic ld1, ld2;

  // Beat that was on the RAM port last cycle: {C2_HI, C2_LO, C1_HI, C1_LO}.
  // RAM read data for that beat arrives in the current cycle.
  logic [3:0] beat_d;

  logic [FPRegWidth-1:0] rdata1, rdata2;
  logic                  rvalid1, rvalid2;

  assign accept = (state == IDLE) && bus.Start;
  assign ld1    = req1 && !wr1;
  assign ld2    = req2 && !wr2;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.Start && bus.CH1_Req)      state_nxt = C1_LO;
        else if (bus.Start && bus.CH2_Req) state_nxt = C2_LO;
      end
      C1_LO:   state_nxt = C1_HI;
      C1_HI:   state_nxt = req2 ? C2_LO : FIN;
      C2_LO:   state_nxt = C2_HI;
      C2_HI:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (RAM port drive, Freeze, Busy)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.dAddr  = '0;
    bus.dWr    = 1'b0;
    bus.dMemIn = '0;
    case (state)
      C1_LO: begin
        bus.dAddr  = addr1;
        bus.dWr    = wr1;
        bus.dMemIn = wdata1[DataWidth-1:0];
      end
      C1_HI: begin
        // Wraps modulo 2^AddrWidth by truncation.
        bus.dAddr  = addr1 + AddrWidth'(1);
        bus.dWr    = wr1;
        bus.dMemIn = wdata1[FPRegWidth-1:DataWidth];
      end
      C2_LO: begin
        bus.dAddr  = addr2;
        bus.dWr    = wr2;
        bus.dMemIn = wdata2[DataWidth-1:0];
      end
      C2_HI: begin
        bus.dAddr  = addr2 + AddrWidth'(1);
        bus.dWr    = wr2;
        bus.dMemIn = wdata2[FPRegWidth-1:DataWidth];
      end
      default: ;
    endcase
    // No RAM write may happen in a reset cycle, even mid-transfer.
    if (Reset) bus.dWr = 1'b0;

    bus.Busy   = (state != IDLE);
    // Freeze rises combinationally in the accepting cycle so decode does not
    // advance past the bundle that issued the request.
    bus.Freeze = (state != IDLE) ||
                 (bus.Start && (bus.CH1_Req || bus.CH2_Req));
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (Reset) begin
      req1   <= 1'b0;
      wr1    <= 1'b0;
      addr1  <= '0;
      wdata1 <= '0;
      req2   <= 1'b0;
      wr2    <= 1'b0;
      addr2  <= '0;
      wdata2 <= '0;
    end else if (accept) begin
      req1   <= bus.CH1_Req;
      wr1    <= bus.CH1_Wr;
      addr1  <= bus.CH1_Addr;
      wdata1 <= bus.CH1_WData;
      req2   <= bus.CH2_Req;
      wr2    <= bus.CH2_Wr;
      addr2  <= bus.CH2_Addr;
      wdata2 <= bus.CH2_WData;
    end
  end

  // ---------------------------------------------------------------------------
  // Load data assembly and completion pulses
  // ---------------------------------------------------------------------------
  // RAM data lags its address by one cycle, so each half is captured one cycle
  // after its beat, overlapping the next beat (or FIN for the last one).
  always_ff @(posedge clock) begin
    if (Reset) begin
      beat_d  <= '0;
      rdata1  <= '0;
      rdata2  <= '0;
      rvalid1 <= 1'b0;
      rvalid2 <= 1'b0;
    end else begin
      beat_d <= {state == C2_HI, state == C2_LO, state == C1_HI, state == C1_LO};
      if (beat_d[0] && ld1) rdata1[DataWidth-1:0]          <= bus.dMemOut;
      if (beat_d[1] && ld1) rdata1[FPRegWidth-1:DataWidth] <= bus.dMemOut;
      if (beat_d[2] && ld2) rdata2[DataWidth-1:0]          <= bus.dMemOut;
      if (beat_d[3] && ld2) rdata2[FPRegWidth-1:DataWidth] <= bus.dMemOut;
      // Both pulses land together in the IDLE cycle after FIN, when the last
      // high word has just been captured.
      rvalid1 <= (state == FIN) && ld1;
      rvalid2 <= (state == FIN) && ld2;
    end
  end

  assign bus.CH1_RData  = rdata1;
  assign bus.CH2_RData  = rdata2;
  assign bus.CH1_RValid = rvalid1;
  assign bus.CH2_RValid = rvalid2;

endmodule

// File: tb/tb_fp_mem_sequencer.sv
module tb_fp_mem_sequencer;
  logic clock = 1'b0;
  logic Reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  fp_mem_sequencer_if #(.FPRegWidth(64), .AddrWidth(20), .DataWidth(32)) bus ();

  fp_mem_sequencer #(.FPRegWidth(64), .AddrWidth(20), .DataWidth(32)) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Data RAM model: synchronous write, read data valid the cycle after address.
  // A backdoor preload port is used only while the DUT is not writing.
  bit [31:0]   mem [0:1048575];
  logic        pre_we;
  logic [19:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clock) begin
    if (bus.dWr)     mem[bus.dAddr] <= bus.dMemIn;
    else if (pre_we) mem[pre_addr]  <= pre_data;
    bus.dMemOut <= mem[bus.dAddr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [19:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    cyc();
    pre_we = 1'b0;
  endtask

  task automatic req(input logic r1, input logic w1, input logic [19:0] a1, input logic [63:0] d1,
                     input logic r2, input logic w2, input logic [19:0] a2, input logic [63:0] d2);
    bus.CH1_Req = r1; bus.CH1_Wr = w1; bus.CH1_Addr = a1; bus.CH1_WData = d1;
    bus.CH2_Req = r2; bus.CH2_Wr = w2; bus.CH2_Addr = a2; bus.CH2_WData = d2;
  endtask

  initial begin
    bus.Start = 1'b0;
    req(0, 0, '0, '0, 0, 0, '0, '0);
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    Reset = 1'b1;

    // ---------------- reset ----------------
    cyc(); cyc();
    #1;
    chk("rst_dwr", bus.dWr, 1'b0);
    Reset = 1'b0;
    cyc(); #1;
    chk("rst_freeze", bus.Freeze, 1'b0);
    chk("rst_busy", bus.Busy, 1'b0);
    chk("rst_daddr", bus.dAddr, 20'h0);
    chk("rst_dmemin", bus.dMemIn, 32'h0);
    chk("rst_rdata1", bus.CH1_RData, 64'h0);
    chk("rst_rdata2", bus.CH2_RData, 64'h0);
    chk("rst_rvalid", {bus.CH1_RValid, bus.CH2_RValid}, 2'b00);

    // ---------------- Start with no request: no-op ----------------
    bus.Start = 1'b1; #1;
    chk("noreq_freeze", bus.Freeze, 1'b0);
    cyc(); bus.Start = 1'b0; #1;
    chk("noreq_busy", bus.Busy, 1'b0);
    cyc(); #1;
    chk("noreq_rvalid", {bus.CH1_RValid, bus.CH2_RValid}, 2'b00);

    // ---------------- CH1-only load ----------------
    preload(20'h100, 32'h3FF00000);
    preload(20'h101, 32'h11223344);
    req(1, 0, 20'h100, '0, 0, 0, '0, '0);
    bus.Start = 1'b1; #1;                           // cycle 0
    chk("ld1_c0_freeze", bus.Freeze, 1'b1);
    chk("ld1_c0_busy", bus.Busy, 1'b0);
    cyc(); bus.Start = 1'b0; #1;                    // cycle 1
    chk("ld1_c1_addr", bus.dAddr, 20'h100);
    chk("ld1_c1_dwr", bus.dWr, 1'b0);
    chk("ld1_c1_freeze", bus.Freeze, 1'b1);
    cyc(); #1;                                      // cycle 2
    chk("ld1_c2_addr", bus.dAddr, 20'h101);
    chk("ld1_c2_freeze", bus.Freeze, 1'b1);
    cyc(); #1;                                      // cycle 3 (FIN)
    chk("ld1_c3_freeze", bus.Freeze, 1'b1);
    chk("ld1_c3_addr", bus.dAddr, 20'h0);
    chk("ld1_c3_rvalid", bus.CH1_RValid, 1'b0);
    cyc(); #1;                                      // cycle 4
    chk("ld1_c4_rvalid1", bus.CH1_RValid, 1'b1);
    chk("ld1_c4_rvalid2", bus.CH2_RValid, 1'b0);
    chk("ld1_c4_rdata1", bus.CH1_RData, 64'h11223344_3FF00000);
    chk("ld1_c4_freeze", bus.Freeze, 1'b0);
    cyc(); #1;                                      // cycle 5
    chk("ld1_c5_rvalid1", bus.CH1_RValid, 1'b0);
    chk("ld1_c5_hold", bus.CH1_RData, 64'h11223344_3FF00000);

    // ---------------- dual store ----------------
    req(1, 1, 20'h20, 64'hAAAA0001_BBBB0002, 1, 1, 20'h40, 64'hCCCC0003_DDDD0004);
    bus.Start = 1'b1; #1;
    chk("st2_c0_freeze", bus.Freeze, 1'b1);
    cyc(); bus.Start = 1'b0; #1;                    // cycle 1
    chk("st2_c1", {bus.dWr, 12'h0, bus.dAddr, bus.dMemIn}, {1'b1, 12'h0, 20'h20, 32'hBBBB0002});
    cyc(); #1;
    chk("st2_c2", {bus.dWr, 12'h0, bus.dAddr, bus.dMemIn}, {1'b1, 12'h0, 20'h21, 32'hAAAA0001});
    cyc(); #1;
    chk("st2_c3", {bus.dWr, 12'h0, bus.dAddr, bus.dMemIn}, {1'b1, 12'h0, 20'h40, 32'hDDDD0004});
    cyc(); #1;
    chk("st2_c4", {bus.dWr, 12'h0, bus.dAddr, bus.dMemIn}, {1'b1, 12'h0, 20'h41, 32'hCCCC0003});
    cyc(); #1;                                      // cycle 5 (FIN)
    chk("st2_c5_dwr", bus.dWr, 1'b0);
    chk("st2_c5_freeze", bus.Freeze, 1'b1);
    cyc(); #1;                                      // cycle 6
    chk("st2_c6_rvalid", {bus.CH1_RValid, bus.CH2_RValid}, 2'b00);
    chk("st2_c6_freeze", bus.Freeze, 1'b0);
    chk("st2_mem", {mem[20'h20], mem[20'h21]}, 64'hBBBB0002_AAAA0001);
    chk("st2_mem2", {mem[20'h40], mem[20'h41]}, 64'hDDDD0004_CCCC0003);

    // ---------------- mixed: CH1 store then CH2 load same address ----------------
    req(1, 1, 20'h80, 64'h00000001_00000002, 1, 0, 20'h80, '0);
    bus.Start = 1'b1;
    cyc(); bus.Start = 1'b0;                        // cycle 1
    for (int i = 0; i < 5; i++) cyc();              // cycle 6
    #1;
    chk("mix_rvalid2", bus.CH2_RValid, 1'b1);
    chk("mix_rvalid1", bus.CH1_RValid, 1'b0);
    chk("mix_rdata2", bus.CH2_RData, 64'h00000001_00000002);
    chk("mix_rdata1_hold", bus.CH1_RData, 64'h11223344_3FF00000);

    // ---------------- wrap: CH2 load at top of address space ----------------
    preload(20'hFFFFF, 32'hDEADBEEF);
    preload(20'h00000, 32'hCAFEF00D);
    req(0, 0, '0, '0, 1, 0, 20'hFFFFF, '0);
    bus.Start = 1'b1; #1;
    chk("wrap_c0_freeze", bus.Freeze, 1'b1);
    cyc(); bus.Start = 1'b0; #1;
    chk("wrap_c1_addr", bus.dAddr, 20'hFFFFF);
    cyc(); #1;
    chk("wrap_c2_addr", bus.dAddr, 20'h00000);
    cyc(); cyc(); #1;                               // cycle 4
    chk("wrap_rvalid", {bus.CH1_RValid, bus.CH2_RValid}, 2'b01);
    chk("wrap_rdata2", bus.CH2_RData, 64'hCAFEF00D_DEADBEEF);

    // ---------------- Start while busy is ignored ----------------
    cyc();
    req(1, 0, 20'h20, '0, 1, 0, 20'h40, '0);
    bus.Start = 1'b1;
    cyc(); bus.Start = 1'b0;                        // cycle 1
    cyc();                                          // cycle 2: stray Start
    req(1, 1, 20'h300, 64'hFFFF, 1, 1, 20'h400, 64'hEEEE);
    bus.Start = 1'b1; #1;
    chk("busy_c2_addr", bus.dAddr, 20'h21);
    chk("busy_c2_dwr", bus.dWr, 1'b0);
    cyc(); bus.Start = 1'b0; #1;                    // cycle 3
    chk("busy_c3_addr", bus.dAddr, 20'h40);
    cyc(); #1;
    chk("busy_c4_addr", bus.dAddr, 20'h41);
    cyc(); cyc(); #1;                               // cycle 6
    chk("busy_rvalid", {bus.CH1_RValid, bus.CH2_RValid}, 2'b11);
    chk("busy_rdata1", bus.CH1_RData, 64'hAAAA0001_BBBB0002);
    chk("busy_rdata2", bus.CH2_RData, 64'hCCCC0003_DDDD0004);
    cyc(); #1;                                      // cycle 7
    chk("busy_c7_idle", {bus.Busy, bus.CH1_RValid, bus.CH2_RValid}, 3'b000);

    // ---------------- reset in the middle of a dual store ----------------
    preload(20'h21, 32'h5A5A5A5A);
    preload(20'h40, 32'h5A5A5A5A);
    preload(20'h41, 32'h5A5A5A5A);
    req(1, 1, 20'h20, 64'h12345678_9ABCDEF0, 1, 1, 20'h40, 64'h0BADF00D_0BADF00D);
    bus.Start = 1'b1;
    cyc(); bus.Start = 1'b0; #1;                    // cycle 1
    chk("rstm_c1_dwr", bus.dWr, 1'b1);
    cyc();                                          // cycle 2: reset
    Reset = 1'b1; #1;
    chk("rstm_c2_dwr", bus.dWr, 1'b0);
    chk("rstm_c2_freeze", bus.Freeze, 1'b1);
    cyc(); Reset = 1'b0; #1;                        // cycle 3
    chk("rstm_c3_busy", bus.Busy, 1'b0);
    chk("rstm_c3_freeze", bus.Freeze, 1'b0);
    chk("rstm_c3_addr", bus.dAddr, 20'h0);
    chk("rstm_c3_rdata", {bus.CH1_RData, bus.CH2_RData}, 128'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("rstm_after", {bus.Freeze, bus.dWr, bus.CH1_RValid, bus.CH2_RValid, bus.dAddr},
          {4'b0000, 20'h0});
    end
    chk("rstm_mem20", mem[20'h20], 32'h9ABCDEF0);
    chk("rstm_mem21", mem[20'h21], 32'h5A5A5A5A);
    chk("rstm_mem40", {mem[20'h40], mem[20'h41]}, 64'h5A5A5A5A_5A5A5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_mem_sequencer.md
Name: fp_mem_sequencer

Overview:
- Sequences 64-bit FP register loads/stores from both VLIW FP channels (CH1, CH2) over the single 32-bit data-RAM port.
- Each channel's transfer is split into a low-word beat and a high-word beat. Channels are serviced CH1 first, then CH2.
- The block freezes instruction fetch/decode until both transfers complete.
- It sits between the decode stage (FP memory request fields) and the data-RAM port (dAddr/dWr/dMemIn/dMemOut).

Parameters:
- FPRegWidth, 64, FP register width; must be 2*DataWidth.
- AddrWidth, 20, data-RAM word address width.
- DataWidth, 32, data-RAM word width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle strobe; samples both channel requests when the block is idle.
- CH1_Req  in  1  CH1 has an FP memory transfer in this bundle.
- CH1_Wr  in  1  1 = store, 0 = load.
- CH1_Addr  in  AddrWidth  word address of the low word.
- CH1_WData  in  FPRegWidth  store data; [31:0] is the low word.
- CH2_Req, CH2_Wr, CH2_Addr, CH2_WData  in  same widths as CH1  same meanings for CH2.
- dMemOut  in  DataWidth  RAM read data; valid the cycle after its address is driven.
- dAddr  out  AddrWidth  RAM word address.
- dWr  out  1  RAM write enable.
- dMemIn  out  DataWidth  RAM write data.
- Freeze  out  1  stalls fetch/decode.
- Busy  out  1  state != IDLE.
- CH1_RData  out  FPRegWidth  assembled load data for CH1.
- CH2_RData  out  FPRegWidth  assembled load data for CH2.
- CH1_RValid  out  1  one-cycle load-complete pulse for CH1.
- CH2_RValid  out  1  one-cycle load-complete pulse for CH2.

Behaviour:
- States: IDLE, C1_LO, C1_HI, C2_LO, C2_HI, FIN.
- Start accept: Start is accepted only in IDLE. On accept, Req/Wr/Addr/WData of both channels are captured into internal registers. Start in any other state is ignored.
- Transitions:
  - IDLE: to C1_LO if Start&CH1_Req; else to C2_LO if Start&CH2_Req; else stay.
  - C1_LO to C1_HI.
  - C1_HI to C2_LO if captured CH2 request; else to FIN.
  - C2_LO to C2_HI.
  - C2_HI to FIN.
  - FIN to IDLE.
- Port drive in LO/HI states:
  - dAddr = captured Addr in LO, Addr+1 in HI; addition is modulo 2^AddrWidth (0xFFFFF wraps to 0x00000).
  - dWr = captured Wr.
  - dMemIn = WData[31:0] in LO, WData[63:32] in HI.
- Port drive in IDLE and FIN: dAddr=0, dWr=0, dMemIn=0.
- Read capture, for load channels only:
  - Low word: dMemOut is captured into RData[31:0] at the end of the cycle after the LO state.
  - High word: dMemOut is captured into RData[63:32] at the end of the cycle after the HI state.
  - The cycle after C1_HI is either C2_LO or FIN; captures overlap with the next beat.
- CH1_RValid / CH2_RValid:
  - Both are registered and pulse together for exactly one cycle, in the IDLE cycle following FIN.
  - Each pulses only if that channel's captured request was a load.
  - RData holds its value until the next load for that channel completes.
- Freeze (combinational): 1 when state is IDLE with Start&(CH1_Req|CH2_Req); 1 in every non-IDLE state; 0 otherwise.
- Latency from the Start cycle:
  - One request: RValid is 4 cycles after Start; Freeze is high for 4 cycles.
  - Two requests: RValid is 6 cycles after Start; Freeze is high for 6 cycles.
- Start with neither request set: no-op; Freeze=0, no RValid.
- Both channels store to the same address: the CH2 write lands last and wins.
- Load and store overlapping: CH1 is serviced first, so a CH2 load sees CH1's store data.
- Reset:
  - Next state is IDLE. CH1_RData and CH2_RData clear to 0. RValid outputs and internal capture registers clear to 0.
  - dWr is forced to 0 combinationally while Reset=1, so no RAM write occurs in the reset cycle.
  - Reset mid-transfer aborts it: no RValid pulse; any beats already written stay in RAM.
- After reset: Freeze=0, Busy=0, dAddr=0, dWr=0, dMemIn=0.

Test Plan:
- CH1-only load: RAM[0x100]=0x3FF00000, RAM[0x101]=0x11223344; Start with CH1_Req=1, CH1_Wr=0, CH1_Addr=0x100 -> CH1_RData=0x11223344_3FF00000 and CH1_RValid=1 at cycle 4; CH2_RValid=0; Freeze high in cycles 0-3.
- Dual store: CH1 stores 0xAAAA0001_BBBB0002 at 0x20; CH2 stores 0xCCCC0003_DDDD0004 at 0x40 -> dWr beats in cycles 1-4 at addresses 0x20, 0x21, 0x40, 0x41 with data 0xBBBB0002, 0xAAAA0001, 0xDDDD0004, 0xCCCC0003; no RValid pulse.
- Mixed: CH1 stores 0x1_2 at 0x80, CH2 loads from 0x80 -> CH2_RData=0x00000001_00000002 at cycle 6; CH1_RValid=0.
- Wrap: CH2 load at 0xFFFFF -> address sequence 0xFFFFF, 0x00000; RData={RAM[0],RAM[0xFFFFF]}.
- Start while busy: a second Start at cycle 2 with different addresses -> ignored; the original transfer completes unchanged.
- Reset at cycle 2 of a dual store -> IDLE next cycle; dWr=0 during the reset cycle; CH2 addresses never driven; Freeze=0 afterwards.
